// File: rtl/tag_ram_nway_if.sv
// Request/response bus for the N-way tag RAM.
interface tag_ram_nway_if #(
   parameter int unsigned IDX_WIDTH     = 6,
   parameter int unsigned TAG_WIDTH     = 20,
   parameter int unsigned PAYLOAD_WIDTH = 32,
   parameter int unsigned WAYS          = 4
);
   localparam int unsigned WAY_W = $clog2(WAYS);

   logic                     req_valid;
   logic                     req_ready;
   logic [1:0]               req_op;
   logic [IDX_WIDTH-1:0]     req_idx;
   logic [TAG_WIDTH-1:0]     req_tag;
   logic [PAYLOAD_WIDTH-1:0] req_payload;
   logic                     resp_valid;
   logic                     resp_hit;
   logic [WAY_W-1:0]         resp_way;
   logic [PAYLOAD_WIDTH-1:0] resp_payload;

   modport master (
      output req_valid, req_op, req_idx, req_tag, req_payload,
      input  req_ready, resp_valid, resp_hit, resp_way, resp_payload
   );

   modport slave (
      input  req_valid, req_op, req_idx, req_tag, req_payload,
      output req_ready, resp_valid, resp_hit, resp_way, resp_payload
   );
endinterface

// File: rtl/tag_ram_nway.sv
// N-way set-associative tag/payload array with tree pseudo-LRU replacement,
// single-entry invalidate and a multi-cycle flush-all sweep.
module tag_ram_nway #(
   parameter int unsigned IDX_WIDTH     = 6,
   parameter int unsigned TAG_WIDTH     = 20,
   parameter int unsigned PAYLOAD_WIDTH = 32,
   parameter int unsigned WAYS          = 4
) (
   input logic           clk,
   input logic           resetn,
   tag_ram_nway_if.slave bus
);
   localparam int unsigned LINES = 2 ** IDX_WIDTH;
   localparam int          WAY_W = $clog2(WAYS);
   localparam int unsigned NODES = WAYS - 1;

   localparam logic [1:0] OpLookup = 2'b00;
   localparam logic [1:0] OpFill   = 2'b01;
   localparam logic [1:0] OpInval  = 2'b10;
   localparam logic [1:0] OpFlush  = 2'b11;

   typedef enum logic [0:0] {StIdle, StFlush} state_e;

   state_e                   state_q;
   logic [IDX_WIDTH-1:0]     cnt_q;
   logic [WAYS-1:0]          valid_q   [LINES];
   logic [NODES-1:0]         plru_q    [LINES];
   logic [TAG_WIDTH-1:0]     tag_q     [WAYS][LINES];
   logic [PAYLOAD_WIDTH-1:0] payload_q [WAYS][LINES];

   logic                     resp_valid_q, resp_hit_q;
   logic [WAY_W-1:0]         resp_way_q;
   logic [PAYLOAD_WIDTH-1:0] resp_payload_q;

   logic                     ready, accept;
   logic [WAYS-1:0]          set_valid, hit_vec;
   logic [NODES-1:0]         set_plru, plru_new;
   logic                     hit_any, inv_any;
   logic [WAY_W-1:0]         hit_way, inv_way, victim, fill_way, touch_way, tw, node;
   logic                     bit_v;
   logic [PAYLOAD_WIDTH-1:0] hit_payload;

   assign ready            = (state_q == StIdle);
   assign accept           = bus.req_valid && ready;
   assign bus.req_ready    = ready;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_hit     = resp_hit_q;
   assign bus.resp_way     = resp_way_q;
   assign bus.resp_payload = resp_payload_q;

   // Tag match, fill-way selection and PLRU victim/touch for the addressed set.
   always_comb begin
      set_valid = valid_q[bus.req_idx];
      set_plru  = plru_q[bus.req_idx];
      hit_vec   = '0;
      hit_way   = '0;
      inv_way   = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         hit_vec[w] = set_valid[w] && (tag_q[w][bus.req_idx] == bus.req_tag);
         if (hit_vec[w]) hit_way = WAY_W'(w);
      end
      // Descending scan so the lowest-index invalid way wins.
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (!set_valid[w]) inv_way = WAY_W'(w);
      end
      hit_any     = |hit_vec;
      inv_any     = ~&set_valid;
      hit_payload = payload_q[hit_way][bus.req_idx];

      // Victim: walk from the root, each node bit picks the half to descend into.
      victim = '0;
      node   = '0;
      bit_v  = 1'b0;
      for (int l = 0; l < WAY_W; l++) begin
         bit_v  = set_plru[node];
         victim = WAY_W'({victim, bit_v});
         node   = WAY_W'(2 * int'(node) + 1 + int'(bit_v));
      end

      fill_way  = hit_any ? hit_way : (inv_any ? inv_way : victim);
      touch_way = (bus.req_op == OpFill) ? fill_way : hit_way;

      // Touch: every node on the path points away from the touched way.
      plru_new = set_plru;
      tw       = touch_way;
      node     = '0;
      for (int l = 0; l < WAY_W; l++) begin
         bit_v          = tw[WAY_W-1];
         plru_new[node] = ~bit_v;
         node           = WAY_W'(2 * int'(node) + 1 + int'(bit_v));
         tw             = tw << 1;
      end
   end

   // Control FSM, valid/PLRU state and the registered response.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         resp_valid_q   <= 1'b0;
         resp_hit_q     <= 1'b0;
         resp_way_q     <= '0;
         resp_payload_q <= '0;
         for (int s = 0; s < int'(LINES); s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         resp_valid_q   <= 1'b0;
         resp_hit_q     <= 1'b0;
         resp_way_q     <= '0;
         resp_payload_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  unique case (bus.req_op)
                     OpLookup: begin
                        resp_valid_q   <= 1'b1;
                        resp_hit_q     <= hit_any;
                        resp_way_q     <= hit_way;
                        resp_payload_q <= hit_any ? hit_payload : '0;
                        if (hit_any) plru_q[bus.req_idx] <= plru_new;
                     end
                     OpFill: begin
                        valid_q[bus.req_idx][fill_way] <= 1'b1;
                        plru_q[bus.req_idx]            <= plru_new;
                        resp_valid_q                   <= 1'b1;
                        resp_hit_q                     <= hit_any;
                        resp_way_q                     <= fill_way;
                     end
                     OpInval: begin
                        if (hit_any) valid_q[bus.req_idx][hit_way] <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= hit_any;
                        resp_way_q   <= hit_way;
                     end
                     OpFlush: begin
                        state_q <= StFlush;
                        cnt_q   <= '0;
                     end
                  endcase
               end
            end
            StFlush: begin
               valid_q[cnt_q] <= '0;
               plru_q[cnt_q]  <= '0;
               cnt_q          <= cnt_q + 1'b1;
               if (&cnt_q) begin
                  state_q      <= StIdle;
                  resp_valid_q <= 1'b1;
               end
            end
         endcase
      end
   end

   // Tag and payload storage; not reset, gated by the valid bits.
   always_ff @(posedge clk) begin
      if (accept && bus.req_op == OpFill) begin
         tag_q[fill_way][bus.req_idx]     <= bus.req_tag;
         payload_q[fill_way][bus.req_idx] <= bus.req_payload;
      end
   end
endmodule

// File: tb/tb_tag_ram_nway.sv
// Randomized and directed bench for tag_ram_nway against a set/way array model.
module tb_tag_ram_nway;
   localparam int IW = 2;
   localparam int TW = 8;
   localparam int PW = 16;
   localparam int WAYS = 4;
   localparam int LINES = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int total = 0;
   int bad = 0;

   tag_ram_nway_if #(.IDX_WIDTH(IW), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW), .WAYS(WAYS)) bus ();
   tag_ram_nway #(.IDX_WIDTH(IW), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW), .WAYS(WAYS)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Reference model state.
   bit          m_valid [LINES][WAYS];
   logic [7:0]  m_tag   [LINES][WAYS];
   logic [15:0] m_pay   [LINES][WAYS];
   bit          m_plru  [LINES][WAYS-1];

   task automatic model_clear();
      for (int s = 0; s < LINES; s++) begin
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
         for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 0;
      end
   endtask

   function automatic int model_victim(int s);
      int lo = 0, size = WAYS, node = 0, half;
      while (size > 1) begin
         half = size / 2;
         if (m_plru[s][node]) begin lo += half; node = 2 * node + 2; end
         else node = 2 * node + 1;
         size = half;
      end
      return lo;
   endfunction

   task automatic model_touch(int s, int w);
      int lo = 0, size = WAYS, node = 0, half;
      while (size > 1) begin
         half = size / 2;
         if (w < lo + half) begin m_plru[s][node] = 1; node = 2 * node + 1; end
         else begin m_plru[s][node] = 0; lo += half; node = 2 * node + 2; end
         size = half;
      end
   endtask

   function automatic int model_match(int s, logic [7:0] tag);
      for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == tag) return w;
      return -1;
   endfunction

   // Expected response for a non-flush op, updating the model.
   task automatic model_op(input logic [1:0] op, input int s, input logic [7:0] tag,
                           input logic [15:0] pay, output logic eh, output logic [1:0] ew,
                           output logic [15:0] ep);
      int h = model_match(s, tag);
      int w;
      eh = (h >= 0);
      ew = eh ? 2'(h) : 2'd0;
      ep = 16'h0;
      if (op == 2'b00) begin
         if (eh) begin ep = m_pay[s][h]; model_touch(s, h); end
      end else if (op == 2'b01) begin
         if (eh) w = h;
         else begin
            w = -1;
            for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
            if (w < 0) w = model_victim(s);
         end
         m_valid[s][w] = 1; m_tag[s][w] = tag; m_pay[s][w] = pay;
         model_touch(s, w);
         ew = 2'(w);
      end else if (op == 2'b10) begin
         if (eh) m_valid[s][h] = 0;
      end
   endtask

   task automatic apply_reset();
      bus.req_valid = 1'b0;
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      model_clear();
   endtask

   task automatic send(input logic [1:0] op, input int s, input logic [7:0] tag,
                       input logic [15:0] pay, output logic rdy, output logic rv,
                       output logic rh, output logic [1:0] rw, output logic [15:0] rp);
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_idx = 2'(s);
      bus.req_tag = tag; bus.req_payload = pay;
      rdy = bus.req_ready;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      rv = bus.resp_valid; rh = bus.resp_hit; rw = bus.resp_way; rp = bus.resp_payload;
   endtask

   // Counts ready-low cycles after a flush is accepted, bounded.
   task automatic wait_flush(output int low, output logic rv, output logic rh);
      low = 0;
      while (!bus.req_ready && low < 50) begin
         low++;
         @(posedge clk); #1;
      end
      rv = bus.resp_valid; rh = bus.resp_hit;
   endtask

   task automatic test_reset();
      logic rdy, rv, rh; logic [1:0] rw; logic [15:0] rp;
      apply_reset();
      total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid); end
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
      total++; if ({bus.resp_hit, bus.resp_way, bus.resp_payload} !== 19'h0) begin bad++; $display("FAIL reset_resp_fields got=%h want=0", {bus.resp_hit, bus.resp_way, bus.resp_payload}); end
      send(2'b00, 1, 8'h11, 16'h0, rdy, rv, rh, rw, rp);
      total++; if ({rv, rh, rw, rp} !== {1'b1, 1'b0, 2'd0, 16'h0}) begin bad++; $display("FAIL reset_lookup got=%b/%b/%0d/%h want=1/0/0/0", rv, rh, rw, rp); end
   endtask

   task automatic fill_a_set();
      logic rdy, rv, rh, eh; logic [1:0] rw, ew; logic [15:0] rp, ep;
      for (int i = 0; i < 4; i++) begin
         model_op(2'b01, 1, 8'hA0 + 8'(i), 16'h1000 + 16'(i), eh, ew, ep);
         send(2'b01, 1, 8'hA0 + 8'(i), 16'h1000 + 16'(i), rdy, rv, rh, rw, rp);
         total++; if ({rv, rh, rw} !== {1'b1, 1'b0, 2'(i)}) begin bad++; $display("FAIL fill_way_%0d got=%b/%b/%0d want=1/0/%0d", i, rv, rh, rw, i); end
      end
   endtask

   task automatic test_fill_basic();
      logic rdy, rv, rh, eh; logic [1:0] rw, ew; logic [15:0] rp, ep;
      apply_reset();
      fill_a_set();
      model_op(2'b00, 1, 8'hA2, 16'h0, eh, ew, ep);
      send(2'b00, 1, 8'hA2, 16'h0, rdy, rv, rh, rw, rp);
      total++; if ({rv, rh, rw, rp} !== {1'b1, 1'b1, 2'd2, 16'h1002}) begin bad++; $display("FAIL lookup_a2 got=%b/%b/%0d/%h want=1/1/2/1002", rv, rh, rw, rp); end
   endtask

   task automatic test_plru();
      logic rdy, rv, rh, eh; logic [1:0] rw, ew; logic [15:0] rp, ep;
      apply_reset();
      fill_a_set();
      model_op(2'b00, 1, 8'hA0, 16'h0, eh, ew, ep);
      send(2'b00, 1, 8'hA0, 16'h0, rdy, rv, rh, rw, rp);
      total++; if ({rh, rw, rp} !== {1'b1, 2'd0, 16'h1000}) begin bad++; $display("FAIL lookup_a0 got=%b/%0d/%h want=1/0/1000", rh, rw, rp); end
      model_op(2'b01, 1, 8'hB0, 16'h2000, eh, ew, ep);
      send(2'b01, 1, 8'hB0, 16'h2000, rdy, rv, rh, rw, rp);
      total++; if ({rv, rh, rw} !== {1'b1, 1'b0, 2'd2}) begin bad++; $display("FAIL plru_victim got=%b/%b/%0d want=1/0/2", rv, rh, rw); end
      model_op(2'b00, 1, 8'hA2, 16'h0, eh, ew, ep);
      send(2'b00, 1, 8'hA2, 16'h0, rdy, rv, rh, rw, rp);
      total++; if (rh !== 1'b0) begin bad++; $display("FAIL evicted_a2 got=%b want=0", rh); end
      model_op(2'b00, 1, 8'hB0, 16'h0, eh, ew, ep);
      send(2'b00, 1, 8'hB0, 16'h0, rdy, rv, rh, rw, rp);
      total++; if ({rh, rw, rp} !== {1'b1, 2'd2, 16'h2000}) begin bad++; $display("FAIL lookup_b0 got=%b/%0d/%h want=1/2/2000", rh, rw, rp); end
   endtask

   task automatic test_refill_hit();
      logic rdy, rv, rh, eh; logic [1:0] rw, ew; logic [15:0] rp, ep;
      model_op(2'b01, 1, 8'hA1, 16'hBEEF, eh, ew, ep);
      send(2'b01, 1, 8'hA1, 16'hBEEF, rdy, rv, rh, rw, rp);
      total++; if ({rv, rh, rw} !== {1'b1, 1'b1, 2'd1}) begin bad++; $display("FAIL refill_hit got=%b/%b/%0d want=1/1/1", rv, rh, rw); end
      // Every stored tag must still read back as the model holds it.
      for (int i = 0; i < 5; i++) begin
         logic [7:0] t;
         t = (i == 4) ? 8'hB0 : 8'hA0 + 8'(i);
         model_op(2'b00, 1, t, 16'h0, eh, ew, ep);
         send(2'b00, 1, t, 16'h0, rdy, rv, rh, rw, rp);
         total++; if ({rh, rw, rp} !== {eh, ew, ep}) begin bad++; $display("FAIL refill_scan_%h got=%b/%0d/%h want=%b/%0d/%h", t, rh, rw, rp, eh, ew, ep); end
      end
   endtask

   task automatic test_invalidate();
      logic rdy, rv, rh, eh; logic [1:0] rw, ew; logic [15:0] rp, ep;
      model_op(2'b10, 1, 8'hA3, 16'h0, eh, ew, ep);
      send(2'b10, 1, 8'hA3, 16'h0, rdy, rv, rh, rw, rp);
      total++; if ({rv, rh, rw, rp} !== {1'b1, 1'b1, 2'd3, 16'h0}) begin bad++; $display("FAIL inval_a3 got=%b/%b/%0d/%h want=1/1/3/0", rv, rh, rw, rp); end
      model_op(2'b00, 1, 8'hA3, 16'h0, eh, ew, ep);
      send(2'b00, 1, 8'hA3, 16'h0, rdy, rv, rh, rw, rp);
      total++; if (rh !== 1'b0) begin bad++; $display("FAIL inval_lookup got=%b want=0", rh); end
      model_op(2'b01, 1, 8'hC0, 16'h3333, eh, ew, ep);
      send(2'b01, 1, 8'hC0, 16'h3333, rdy, rv, rh, rw, rp);
      total++; if ({rh, rw} !== {1'b0, 2'd3}) begin bad++; $display("FAIL inval_refill got=%b/%0d want=0/3", rh, rw); end
   endtask

   task automatic test_flush();
      logic rdy, rv, rh, eh; logic [1:0] rw, ew; logic [15:0] rp, ep; int low;
      for (int s = 0; s < LINES; s++) begin
         model_op(2'b01, s, 8'h60 + 8'(s), 16'h4000 + 16'(s), eh, ew, ep);
         send(2'b01, s, 8'h60 + 8'(s), 16'h4000 + 16'(s), rdy, rv, rh, rw, rp);
      end
      send(2'b11, 0, 8'h0, 16'h0, rdy, rv, rh, rw, rp);
      total++; if (rv !== 1'b0) begin bad++; $display("FAIL flush_early_resp got=%b want=0", rv); end
      wait_flush(low, rv, rh);
      model_clear();
      total++; if (low !== 4) begin bad++; $display("FAIL flush_busy_cycles got=%0d want=4", low); end
      total++; if ({rv, rh} !== 2'b10) begin bad++; $display("FAIL flush_resp got=%b/%b want=1/0", rv, rh); end
      for (int s = 0; s < LINES; s++) begin
         send(2'b00, s, 8'h60 + 8'(s), 16'h0, rdy, rv, rh, rw, rp);
         total++; if ({rv, rh} !== 2'b10) begin bad++; $display("FAIL flush_lookup_%0d got=%b/%b want=1/0", s, rv, rh); end
      end
   endtask

   task automatic test_reset_mid_flush();
      logic rdy, rv, rh; logic [1:0] rw; logic [15:0] rp; bit seen = 0;
      send(2'b11, 0, 8'h0, 16'h0, rdy, rv, rh, rw, rp);
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      model_clear();
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL midflush_ready got=%b want=1", bus.req_ready); end
      for (int i = 0; i < 8; i++) begin
         if (bus.resp_valid !== 1'b0) seen = 1;
         @(posedge clk); #1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midflush_resp got=%b want=0", seen); end
   endtask

   task automatic test_back_to_back();
      logic rdy, rv, rh, eh; logic [1:0] rw, ew; logic [15:0] rp, ep;
      model_op(2'b01, 2, 8'h77, 16'h7777, eh, ew, ep);
      send(2'b01, 2, 8'h77, 16'h7777, rdy, rv, rh, rw, rp);
      model_op(2'b00, 2, 8'h77, 16'h0, eh, ew, ep);
      send(2'b00, 2, 8'h77, 16'h0, rdy, rv, rh, rw, rp);
      total++; if ({rdy, rv, rh, rw, rp} !== {2'b11, eh, ew, ep}) begin bad++; $display("FAIL b2b_raw got=%b/%b/%b/%0d/%h want=1/1/%b/%0d/%h", rdy, rv, rh, rw, rp, eh, ew, ep); end
   endtask

   task automatic test_random();
      logic rdy, rv, rh, eh; logic [1:0] rw, ew, op; logic [15:0] rp, ep, pay;
      logic [7:0] tag; int s, r, low;
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 99));
         op = (r < 40) ? 2'b00 : (r < 75) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
         s = int'($urandom_range(0, LINES - 1));
         tag = 8'h50 + 8'($urandom_range(0, 5));
         pay = 16'($urandom);
         if (op == 2'b11) begin
            send(op, s, tag, pay, rdy, rv, rh, rw, rp);
            wait_flush(low, rv, rh);
            model_clear();
            total++; if ({rdy, low, rv, rh} !== {1'b1, 32'd4, 2'b10}) begin bad++; $display("FAIL rnd_flush_%0d got=%b/%0d/%b/%b want=1/4/1/0", n, rdy, low, rv, rh); end
         end else begin
            model_op(op, s, tag, pay, eh, ew, ep);
            send(op, s, tag, pay, rdy, rv, rh, rw, rp);
            total++; if ({rdy, rv} !== 2'b11) begin bad++; $display("FAIL rnd_handshake_%0d got=%b/%b want=1/1", n, rdy, rv); end
            total++; if ({rh, rw, rp} !== {eh, ew, ep}) begin bad++; $display("FAIL rnd_resp_%0d op=%0d got=%b/%0d/%h want=%b/%0d/%h", n, op, rh, rw, rp, eh, ew, ep); end
         end
      end
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_idx = '0;
      bus.req_tag = '0; bus.req_payload = '0;
      test_reset();
      test_fill_basic();
      test_plru();
      test_refill_hit();
      test_invalidate();
      test_back_to_back();
      test_flush();
      test_reset_mid_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tag_ram_nway.md
Name: tag_ram_nway

Overview:
- Parametrised N-way set-associative tag/payload array for the MMU. It is the successor of the 2-way, 1-bit-LRU tag RAM.
- Adds:
  - arbitrary power-of-2 associativity with tree pseudo-LRU,
  - invalid-way-first fill and in-place update when the filled tag already hits,
  - single-entry invalidate,
  - multi-cycle flush-all sequencer,
  - valid/ready request interface with a registered response.
- Sits between the page-walk/fill logic and the translation lookup path.

Parameters:
- IDX_WIDTH, 6, set index width; LINES = 2**IDX_WIDTH sets.
- TAG_WIDTH, 20, stored tag width.
- PAYLOAD_WIDTH, 32, stored payload width (PTE/PPN + attributes).
- WAYS, 4, associativity; power of 2, WAYS >= 2. WAY_W = log2(WAYS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  2  operation: 00 lookup, 01 fill, 10 invalidate entry, 11 flush all.
- req_idx  in  IDX_WIDTH  set index; ignored for flush.
- req_tag  in  TAG_WIDTH  tag; ignored for flush.
- req_payload  in  PAYLOAD_WIDTH  fill data; used by fill only.
- resp_valid  out  1  one-cycle pulse, response to the accepted request.
- resp_hit  out  1  tag matched a valid way (lookup/fill/invalidate); 0 for flush.
- resp_way  out  WAY_W  matched way (lookup/invalidate) or written way (fill); 0 on miss/flush.
- resp_payload  out  PAYLOAD_WIDTH  payload of the hit way (lookup); 0 otherwise.

Behaviour:
- Reset (resetn=0 at an edge):
  - All valid bits and PLRU bits cleared.
  - FSM to IDLE, flush counter 0.
  - resp_valid=0, resp_hit=0, resp_way=0, resp_payload=0; req_ready=1 the following cycle.
  - Tags and payloads are not reset.
  - Reset during FLUSH aborts the flush; no response is issued.
- FSM:
  - IDLE: req_ready=1.
  - Accepted op 11 → FLUSH.
  - FLUSH: req_ready=0. At each edge, clear valid and PLRU of set cnt, then cnt++.
  - After the edge clearing set LINES-1 → IDLE, with resp_valid=1 and resp_hit=0 in that same cycle. A flush accepted at edge E0 therefore responds in the cycle after edge E_LINES.
- Matching is combinational on the array state in the accept cycle: hit_w = v[idx][w] && tags[w][idx]==req_tag.
  - The design guarantees at most one hit per set, because fill never duplicates a tag.
- Response: all ops other than flush respond exactly one cycle after acceptance (resp_valid registered). Back-to-back requests are accepted every cycle in IDLE.
- Lookup:
  - resp_hit/resp_way/resp_payload from the match.
  - A hit touches PLRU for the hit way; a miss leaves PLRU unchanged.
- Fill — the written way is chosen by priority:
  - (1) the hitting way, overwriting the payload only, with resp_hit=1;
  - (2) else the lowest-index invalid way;
  - (3) else the PLRU victim.
  - The chosen way's tag and payload are written and its valid bit set; PLRU is touched for that way.
  - resp_way = chosen way, resp_hit = case (1), resp_payload=0.
- Invalidate:
  - On a hit, clear the valid bit of that way; PLRU unchanged.
  - resp_hit/resp_way report the match; a miss is a no-op.
- Tree PLRU: WAYS-1 bits per set, node 0 = root, children of n are 2n+1 (lower half of ways) and 2n+2 (upper half).
  - Victim: from the root, bit 0 → go lower, bit 1 → go upper. With all bits 0 the victim is way 0.
  - Touch way w: every node on w's path is set to point away from w (1 if w is in the lower half, 0 if in the upper half).
- Read-after-write: a request accepted the cycle after a fill/invalidate to the same set sees the updated contents.
- The flush sweep overrides nothing in flight; a response to the prior op still emits normally in the cycle after FLUSH entry.

Test Plan (IDX_WIDTH=2, WAYS=4, TAG_WIDTH=8, PAYLOAD_WIDTH=16):
- Reset, then lookup idx1 tag 0x11 → next cycle resp_valid=1, resp_hit=0, resp_way=0, resp_payload=0.
- Fill idx1 tags 0xA0..0xA3 with payloads 0x1000..0x1003 → resp_way 0,1,2,3 (invalid-first); then lookup tag 0xA2 → resp_hit=1, resp_way=2, resp_payload=0x1002.
- From the fill state above, lookup 0xA0, then fill 0xB0 → PLRU victim is way 2, resp_way=2; lookup 0xA2 misses, lookup 0xB0 hits on way 2.
- Fill idx1 tag 0xA1 payload 0xBEEF when already present → resp_hit=1, resp_way=1; lookup 0xA1 returns 0xBEEF; no other way changes.
- Invalidate idx1 tag 0xA3 → resp_hit=1, resp_way=3; lookup 0xA3 misses; a subsequent fill of a new tag goes to way 3.
- Flush all while sets hold entries → req_ready=0 for exactly 4 cycles, then a resp_valid pulse with resp_hit=0; all lookups then miss. Resetn=0 mid-flush → req_ready=1 the next cycle and no flush response.
